// File: rtl/sipo8_rx_if.sv
// Byte-assembly receiver bus: serial bit stream in, parallel byte with status out.
// master drives the serial side and the consumer handshake; slave is the receiver.
interface sipo8_rx_if;
    logic       s_valid;
    logic       s_bit;
    logic       s_start;
    logic       msb_first;
    logic       out_ready;
    logic       ovr_clr;
    logic [7:0] d_out;
    logic       out_valid;
    logic       overrun;
    logic       timeout;
    logic       par_err;
    logic       busy;

    modport master (
        output s_valid, s_bit, s_start, msb_first, out_ready, ovr_clr,
        input  d_out, out_valid, overrun, timeout, par_err, busy
    );

    modport slave (
        input  s_valid, s_bit, s_start, msb_first, out_ready, ovr_clr,
        output d_out, out_valid, overrun, timeout, par_err, busy
    );
endinterface

// File: rtl/sipo8_rx.sv
// Serial-in parallel-out byte receiver with idle timeout, overrun tracking and
// optional even parity (define SIPO8_RX_PARITY_EN for a 9-bit frame with trailing parity).
module sipo8_rx #(
    parameter int IDLE_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    sipo8_rx_if.slave  bus
);

`ifdef SIPO8_RX_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd8;
`else
    localparam logic [3:0] LAST_BIT = 4'd7;
`endif
    localparam logic [7:0] TO_LIM = 8'(IDLE_TIMEOUT);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t     state_reg, state_next;
    logic [7:0] sr_reg;
    logic [3:0] cnt_reg;
    logic [7:0] idle_reg;
    logic       order_reg;
    logic [7:0] d_out_reg;
    logic       out_valid_reg;
    logic       overrun_reg;
    logic       timeout_reg;
    logic       busy_next;

    logic       start_hit, data_hit, abort, complete, ovr_set;
    logic [7:0] idle_inc, sr_shift, sr_start, done_byte;

    assign start_hit = bus.s_valid & bus.s_start;
    assign data_hit  = bus.s_valid & ~bus.s_start & (state_reg == SHIFT);
    assign idle_inc  = idle_reg + 8'd1;
    assign abort     = (state_reg == SHIFT) & ~bus.s_valid & (idle_inc == TO_LIM);
    assign complete  = data_hit & (cnt_reg == LAST_BIT);
    assign ovr_set   = complete & out_valid_reg & ~bus.out_ready;
    assign sr_shift  = order_reg ? {sr_reg[6:0], bus.s_bit} : {bus.s_bit, sr_reg[7:1]};
    // The start bit lands where the first shifted bit would after a cleared register.
    assign sr_start  = bus.msb_first ? {7'b0, bus.s_bit} : {bus.s_bit, 7'b0};

`ifdef SIPO8_RX_PARITY_EN
    logic par_acc_reg, par_err_reg, done_perr;
    // The parity bit completes the frame but is never shifted into the data.
    assign done_byte = sr_reg;
    assign done_perr = par_acc_reg ^ bus.s_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_acc_reg <= 1'b0;
            par_err_reg <= 1'b0;
        end else begin
            if (start_hit)
                par_acc_reg <= bus.s_bit;
            else if (data_hit)
                par_acc_reg <= par_acc_reg ^ bus.s_bit;
            if (complete && (!out_valid_reg || bus.out_ready))
                par_err_reg <= done_perr;
        end
    end
    assign bus.par_err = par_err_reg;
`else
    assign done_byte   = sr_shift;
    assign bus.par_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start_hit) state_next = SHIFT;
            SHIFT: begin
                if (start_hit)
                    state_next = SHIFT;
                else if (complete || abort)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy_next = 1'b0;
        if (state_reg == SHIFT)
            busy_next = 1'b1;
    end

    // Shift register, bit count and idle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_reg    <= 8'h00;
            cnt_reg   <= 4'd0;
            idle_reg  <= 8'd0;
            order_reg <= 1'b0;
        end else if (start_hit) begin
            sr_reg    <= sr_start;
            cnt_reg   <= 4'd1;
            idle_reg  <= 8'd0;
            order_reg <= bus.msb_first;
        end else if (data_hit) begin
            sr_reg   <= sr_shift;
            cnt_reg  <= complete ? 4'd0 : cnt_reg + 4'd1;
            idle_reg <= 8'd0;
        end else if (state_reg == SHIFT && !bus.s_valid) begin
            idle_reg <= abort ? 8'd0 : idle_inc;
            if (abort)
                cnt_reg <= 4'd0;
        end
    end

    // Output byte, handshake and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            d_out_reg     <= 8'h00;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            timeout_reg <= abort;
            overrun_reg <= ovr_set | (overrun_reg & ~bus.ovr_clr);
            if (complete && (!out_valid_reg || bus.out_ready)) begin
                d_out_reg     <= done_byte;
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.d_out     = d_out_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.overrun   = overrun_reg;
    assign bus.timeout   = timeout_reg;
    assign bus.busy      = busy_next;

endmodule

// File: tb/tb_sipo8_rx.sv
// Directed bench for sipo8_rx: table of whole frames plus hand-written corner sequences.
module tb_sipo8_rx;
    logic clk;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    sipo8_rx_if bus ();

    sipo8_rx #(.IDLE_TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SIPO8_RX_PARITY_EN
    logic par_flip = 1'b0;
    localparam bit DATA_LAST = 1'b0;
`else
    localparam bit DATA_LAST = 1'b1;
`endif

    typedef struct {
        logic       msb;
        logic [7:0] bits;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic st, input logic b, input logic msb, input logic rdy);
        bus.s_valid   = 1'b1;
        bus.s_start   = st;
        bus.s_bit     = b;
        bus.msb_first = msb;
        bus.out_ready = rdy;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // bits[7] is transmitted first; rdy_last raises out_ready on the frame's final bit
    task automatic send_frame(input logic msb, input logic [7:0] bits, input logic rdy_last);
        for (int i = 0; i < 8; i++)
            drive_bit(i == 0, bits[7-i], msb, DATA_LAST && rdy_last && i == 7);
`ifdef SIPO8_RX_PARITY_EN
        drive_bit(1'b0, (^bits) ^ par_flip, msb, rdy_last);
`endif
        bus.s_valid = 1'b0;
        bus.s_start = 1'b0;
    endtask

    task automatic send_partial(input logic msb, input logic [7:0] bits, input int n);
        for (int i = 0; i < n; i++)
            drive_bit(i == 0, bits[7-i], msb, 1'b0);
        bus.s_valid = 1'b0;
        bus.s_start = 1'b0;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'b10100101, 8'hA5};
        vecs[1] = '{1'b0, 8'b10100000, 8'h05};
        vecs[2] = '{1'b1, 8'b00111100, 8'h3C};
        vecs[3] = '{1'b0, 8'b10100101, 8'hA5};
        vecs[4] = '{1'b0, 8'b11110000, 8'h0F};
        vecs[5] = '{1'b1, 8'b11111111, 8'hFF};
        vecs[6] = '{1'b0, 8'b00000001, 8'h80};
        vecs[7] = '{1'b1, 8'b00000001, 8'h01};

        reset = 1'b1;
        bus.s_valid = 1'b0; bus.s_bit = 1'b0; bus.s_start = 1'b0;
        bus.msb_first = 1'b0; bus.out_ready = 1'b0; bus.ovr_clr = 1'b0;
        tick(); tick();
        chk("reset d_out", bus.d_out, 8'h00);
        chk("reset out_valid", {7'b0, bus.out_valid}, 8'h00);
        chk("reset busy", {7'b0, bus.busy}, 8'h00);
        chk("reset overrun", {7'b0, bus.overrun}, 8'h00);
        chk("reset timeout", {7'b0, bus.timeout}, 8'h00);
        chk("reset par_err", {7'b0, bus.par_err}, 8'h00);
        reset = 1'b0;
        tick();

        // data bits without a start in IDLE are ignored
        bus.s_valid = 1'b1; bus.s_bit = 1'b1;
        tick(); tick(); tick();
        bus.s_valid = 1'b0;
        chk("ignore busy", {7'b0, bus.busy}, 8'h00);
        chk("ignore out_valid", {7'b0, bus.out_valid}, 8'h00);

        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].msb, vecs[v].bits, 1'b0);
            $display("vec %0d msb=%0b bits=%08b d_out=%02h exp=%02h", v, vecs[v].msb,
                     vecs[v].bits, bus.d_out, vecs[v].exp);
            chk("vec out_valid", {7'b0, bus.out_valid}, 8'h01);
            chk("vec d_out", bus.d_out, vecs[v].exp);
            chk("vec busy", {7'b0, bus.busy}, 8'h00);
            chk("vec par_err", {7'b0, bus.par_err}, 8'h00);
            consume();
            chk("vec consumed", {7'b0, bus.out_valid}, 8'h00);
        end

        // overrun: second byte dropped while first is unconsumed
        send_frame(1'b1, 8'h11, 1'b0);
        send_frame(1'b1, 8'h22, 1'b0);
        $display("overrun d_out=%02h overrun=%0b", bus.d_out, bus.overrun);
        chk("ovr d_out", bus.d_out, 8'h11);
        chk("ovr flag", {7'b0, bus.overrun}, 8'h01);
        chk("ovr out_valid", {7'b0, bus.out_valid}, 8'h01);
        tick();
        chk("ovr sticky", {7'b0, bus.overrun}, 8'h01);
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        chk("ovr cleared", {7'b0, bus.overrun}, 8'h00);

        // transfer and completion on the same edge: new byte replaces old, no overrun
        send_frame(1'b1, 8'h33, 1'b1);
        $display("same-edge d_out=%02h out_valid=%0b", bus.d_out, bus.out_valid);
        chk("same edge d_out", bus.d_out, 8'h33);
        chk("same edge out_valid", {7'b0, bus.out_valid}, 8'h01);
        chk("same edge overrun", {7'b0, bus.overrun}, 8'h00);
        consume();
        chk("same edge consumed", {7'b0, bus.out_valid}, 8'h00);

        // idle timeout after start plus three bits
        send_partial(1'b1, 8'hA0, 4);
        for (int i = 0; i < 14; i++) tick();
        chk("to pre pulse", {7'b0, bus.timeout}, 8'h00);
        chk("to pre busy", {7'b0, bus.busy}, 8'h01);
        tick();
        $display("timeout pulse=%0b busy=%0b", bus.timeout, bus.busy);
        chk("to pulse", {7'b0, bus.timeout}, 8'h01);
        chk("to busy", {7'b0, bus.busy}, 8'h00);
        chk("to out_valid", {7'b0, bus.out_valid}, 8'h00);
        tick();
        chk("to pulse end", {7'b0, bus.timeout}, 8'h00);

        // restart mid-frame with a fresh start bit
        send_partial(1'b1, 8'hF0, 4);
        send_frame(1'b1, 8'h3C, 1'b0);
        chk("restart d_out", bus.d_out, 8'h3C);
        chk("restart timeout", {7'b0, bus.timeout}, 8'h00);
        consume();

        // reset mid-frame, then a clean frame
        send_partial(1'b1, 8'hFF, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst busy", {7'b0, bus.busy}, 8'h00);
        send_frame(1'b1, 8'h3C, 1'b0);
        $display("post-reset d_out=%02h", bus.d_out);
        chk("midrst d_out", bus.d_out, 8'h3C);
        chk("midrst out_valid", {7'b0, bus.out_valid}, 8'h01);
        consume();

`ifdef SIPO8_RX_PARITY_EN
        par_flip = 1'b1;
        send_frame(1'b1, 8'h3C, 1'b0);
        chk("par bad d_out", bus.d_out, 8'h3C);
        chk("par bad err", {7'b0, bus.par_err}, 8'h01);
        consume();
        chk("par held", {7'b0, bus.par_err}, 8'h01);
        par_flip = 1'b0;
        send_frame(1'b1, 8'h3C, 1'b0);
        chk("par good err", {7'b0, bus.par_err}, 8'h00);
        consume();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
